noc_phase_sequencer: RTL and testbench

NOC_PHASE_SEQUENCER -- requirements
Module: noc_phase_sequencer

---
 rtl/noc_phase_sequencer_pkg.sv | 41 ++++
 rtl/noc_phase_sequencer_seq_counter.sv | 29 ++
 rtl/noc_phase_sequencer.sv | 101 ++++++++++
 tb/tb_noc_phase_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_phase_sequencer_pkg.sv
// Shared encodings for the NoC phase sequencer: FSM states and router op codes.
package noc_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD_RT,
    S_LOAD_STAGING,
    S_PHASE0,
    S_PHASE1,
    S_FINISH
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP          = 3'd0,
    OP_INIT         = 3'd1,
    OP_LOAD_RT      = 3'd2,
    OP_LOAD_STAGING = 3'd3,
    OP_PHASE0       = 3'd4,
    OP_PHASE1       = 3'd5
  } router_op_e;

  function automatic router_op_e state_op(input state_e s);
    router_op_e op;
    op = OP_NOP;
    case (s)
      S_INIT:         op = OP_INIT;
      S_LOAD_RT:      op = OP_LOAD_RT;
      S_LOAD_STAGING: op = OP_LOAD_STAGING;
      S_PHASE0:       op = OP_PHASE0;
      S_PHASE1:       op = OP_PHASE1;
      default:        op = OP_NOP;
    endcase
    return op;
  endfunction

  function automatic logic is_stallable(input state_e s);
    return (s == S_LOAD_STAGING) || (s == S_PHASE0) || (s == S_PHASE1);
  endfunction

endpackage

// File: rtl/noc_phase_sequencer_seq_counter.sv
// Clearable, enabled up-counter that saturates at a limit and flags the step onto it.
module seq_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [Width-1:0] limit,
  output logic [Width-1:0] count,
  output logic             at_limit,
  output logic             last_step
);

  assign at_limit  = (count == limit);
  // Widened so an all-ones count cannot alias onto a zero limit
  assign last_step = (({1'b0, count} + (Width + 1)'(1)) == {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !at_limit) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/noc_phase_sequencer.sv
// Sequences router ops through init, routing-table load and Phase0/Phase1 simulation cycles.
module noc_phase_sequencer
  import noc_phase_sequencer_pkg::*;
#(
  parameter int unsigned RouterSize      = 16,
  parameter int unsigned RouterBitSize   = 4,
  parameter int unsigned MaxCycleBitSize = 16,
  parameter int unsigned op_size         = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [MaxCycleBitSize-1:0] max_cycle,
  input  logic                       all_done,
  input  logic                       stall,
  output logic [op_size-1:0]         router_op,
  output logic [RouterBitSize-1:0]   rt_dst,
  output logic [MaxCycleBitSize-1:0] in_cycle,
  output logic                       finished
);

  localparam logic [RouterBitSize-1:0] RtLast = RouterBitSize'(RouterSize - 1);

  state_e                     state;
  logic [MaxCycleBitSize-1:0] max_lat;
  logic                       start_ok;
  logic                       rt_at_last;
  logic                       cyc_last;
  logic                       rt_unused;
  logic                       cyc_unused;

  assign start_ok = start && ((state == S_IDLE) || (state == S_FINISH));

  // Decoded straight from the state register so stall can squash the op in the same cycle
  assign router_op = (stall && is_stallable(state)) ? op_size'(OP_NOP) : op_size'(state_op(state));

  seq_counter #(.Width(RouterBitSize)) u_rt_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .en        (state == S_LOAD_RT),
    .limit     (RtLast),
    .count     (rt_dst),
    .at_limit  (rt_at_last),
    .last_step (rt_unused)
  );

  seq_counter #(.Width(MaxCycleBitSize)) u_cyc_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .en        ((state == S_PHASE1) && !stall),
    .limit     (max_lat),
    .count     (in_cycle),
    .at_limit  (cyc_unused),
    .last_step (cyc_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      finished <= 1'b0;
      max_lat  <= '0;
    end else begin
      case (state)
        S_IDLE, S_FINISH: begin
          if (start) begin
            state    <= S_INIT;
            max_lat  <= max_cycle;
            finished <= 1'b0;
          end
        end
        S_INIT: state <= S_LOAD_RT;
        S_LOAD_RT: begin
          if (rt_at_last) begin
            if (max_lat == '0) begin
              state    <= S_FINISH;
              finished <= 1'b1;
            end else begin
              state <= S_LOAD_STAGING;
            end
          end
        end
        S_LOAD_STAGING: if (!stall) state <= S_PHASE0;
        S_PHASE0:       if (!stall) state <= S_PHASE1;
        S_PHASE1: begin
          if (!stall) begin
            if (cyc_last || all_done) begin
              state    <= S_FINISH;
              finished <= 1'b1;
            end else begin
              state <= S_LOAD_STAGING;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_phase_sequencer.sv
// Bench for noc_phase_sequencer: op-queue reference model, run table, corner sequences, random runs.
module tb_noc_phase_sequencer;

  localparam int unsigned N   = 4;
  localparam int unsigned RB  = 2;
  localparam int unsigned MB  = 8;
  localparam int unsigned OPW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [MB-1:0] max_cycle;
  logic          all_done;
  logic          stall;
  logic [OPW-1:0] router_op;
  logic [RB-1:0]  rt_dst;
  logic [MB-1:0]  in_cycle;
  logic           finished;

  noc_phase_sequencer #(
    .RouterSize(N),
    .RouterBitSize(RB),
    .MaxCycleBitSize(MB),
    .op_size(OPW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .max_cycle(max_cycle),
    .all_done(all_done),
    .stall(stall),
    .router_op(router_op),
    .rt_dst(rt_dst),
    .in_cycle(in_cycle),
    .finished(finished)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: remaining op sequence of the current run
  int q[$];
  int rt_m  = 0;
  int cyc_m = 0;
  bit fin_m = 1'b0;

  typedef struct {
    int unsigned mc;
    int          done_iter;
    int unsigned exp_cyc;
  } run_vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit stallable(input int op);
    return (op >= 3) && (op <= 5);
  endfunction

  task automatic step(input bit st, input bit sl, input bit ad, input int mc);
    int exp_op;
    int p;
    @(negedge clk);
    start     = st;
    stall     = sl;
    all_done  = ad;
    max_cycle = MB'(mc);
    #1;
    exp_op = 0;
    if (q.size() > 0 && !(sl && stallable(q[0]))) exp_op = q[0];
    check("router_op", int'(router_op), exp_op);
    check("rt_dst", int'(rt_dst), rt_m);
    check("in_cycle", int'(in_cycle), cyc_m);
    check("finished", int'(finished), int'(fin_m));
    if (q.size() == 0) begin
      if (st) begin
        q.push_back(1);
        repeat (N) q.push_back(2);
        repeat (mc) begin
          q.push_back(3);
          q.push_back(4);
          q.push_back(5);
        end
        rt_m  = 0;
        cyc_m = 0;
        fin_m = 1'b0;
      end
    end else if (!(sl && stallable(q[0]))) begin
      p = q.pop_front();
      if (p == 2 && rt_m < int'(N) - 1) rt_m++;
      if (p == 5) begin
        cyc_m++;
        if (ad) q.delete();
      end
      if (q.size() == 0) fin_m = 1'b1;
    end
  endtask

  task automatic drain(input int done_iter, input bit rnd);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 3000) begin
      if (rnd)
        step(($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0, $urandom_range(0, 255));
      else
        step(1'b0, 1'b0, cyc_m == done_iter - 1, $urandom_range(0, 255));
      guard++;
    end
    if (q.size() > 0) check("run_timeout", guard, -1);
  endtask

  task automatic step_to_op(input int op, input int cyc);
    int guard;
    guard = 0;
    while (q.size() > 0 && !(q[0] == op && cyc_m == cyc) && guard < 200) begin
      step(1'b0, 1'b0, 1'b0, 0);
      guard++;
    end
    check("reach_op", (q.size() > 0) ? q[0] : -1, op);
  endtask

  run_vec_t vecs[6];

  initial begin
    vecs[0] = '{mc: 2,   done_iter: -1, exp_cyc: 2};
    vecs[1] = '{mc: 5,   done_iter: 2,  exp_cyc: 2};
    vecs[2] = '{mc: 0,   done_iter: -1, exp_cyc: 0};
    vecs[3] = '{mc: 1,   done_iter: -1, exp_cyc: 1};
    vecs[4] = '{mc: 3,   done_iter: 1,  exp_cyc: 1};
    vecs[5] = '{mc: 255, done_iter: -1, exp_cyc: 255};

    rst = 1'b1; start = 1'b0; stall = 1'b0; all_done = 1'b0; max_cycle = '0;
    #12;
    check("reset_op", int'(router_op), 0);
    check("reset_rt", int'(rt_dst), 0);
    check("reset_cyc", int'(in_cycle), 0);
    check("reset_fin", int'(finished), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, 9);

    // Table of whole runs with expected final cycle count
    foreach (vecs[i]) begin
      step(1'b1, 1'b0, 1'b0, int'(vecs[i].mc));
      drain(vecs[i].done_iter, 1'b0);
      step(1'b0, 1'b0, 1'b0, 0);
      check("table_in_cycle", int'(in_cycle), int'(vecs[i].exp_cyc));
      check("table_finished", int'(finished), 1);
    end

    // Stall three cycles on entering Phase0
    step(1'b1, 1'b0, 1'b0, 3);
    step_to_op(4, 0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    drain(-1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0);
    check("stall_in_cycle", int'(in_cycle), 3);

    // Start held in FINISH restarts; second start during INIT is ignored
    step(1'b1, 1'b0, 1'b0, 2);
    step(1'b1, 1'b0, 1'b0, 7);
    check("restart_fin", int'(finished), 0);
    drain(-1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0);
    check("restart_in_cycle", int'(in_cycle), 2);

    // Asynchronous reset between edges during the second Phase0
    step(1'b1, 1'b0, 1'b0, 4);
    step_to_op(4, 1);
    check("pre_rst_cyc", int'(in_cycle), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_op", int'(router_op), 0);
    check("async_rst_rt", int'(rt_dst), 0);
    check("async_rst_cyc", int'(in_cycle), 0);
    check("async_rst_fin", int'(finished), 0);
    q.delete(); rt_m = 0; cyc_m = 0; fin_m = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b1, 5);
    step(1'b1, 1'b0, 1'b0, 1);
    drain(-1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0);

    // Random runs with stalls, early done and spurious starts
    for (int r = 0; r < 25; r++) begin
      step(1'b1, ($urandom % 4) == 0, 1'b0, $urandom_range(0, 6));
      drain(-1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
